// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - action codes, response classification and FSM states for memory_sequencer
package memory_pkg;

    localparam logic [7:0] ACT_RESET   = 8'd1;
    localparam logic [7:0] ACT_WRITE   = 8'd2;
    localparam logic [7:0] ACT_READ    = 8'd3;
    localparam logic [7:0] ACT_SIZE    = 8'd4;
    localparam logic [7:0] ACT_INC     = 8'd5;
    localparam logic [7:0] ACT_DEC     = 8'd6;
    localparam logic [7:0] ACT_INDEX   = 8'd7;
    localparam logic [7:0] ACT_LESS    = 8'd8;
    localparam logic [7:0] ACT_GREATER = 8'd9;
    localparam logic [7:0] ACT_CLEAR   = 8'd10;
    localparam logic [7:0] ACT_SWAP    = 8'd11;
    localparam logic [7:0] ACT_LONG1   = 8'd12;
    localparam logic [7:0] ACT_LONG2   = 8'd13;
    localparam logic [7:0] ACT_PUSH    = 8'd14;
    localparam logic [7:0] ACT_POP     = 8'd15;
    localparam logic [7:0] ACT_SORT    = 8'd16;
    localparam logic [7:0] ACT_RESIZE  = 8'd17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } seq_state_t;

    function automatic logic has_response(input logic [7:0] action);
        case (action)
            ACT_WRITE, ACT_READ, ACT_SIZE, ACT_INDEX,
            ACT_LESS, ACT_GREATER, ACT_POP: has_response = 1'b1;
            default:                        has_response = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [7:0] action);
        is_legal = (action >= ACT_RESET) && (action <= ACT_RESIZE);
    endfunction

endpackage

// File: rtl/memory_sequencer_fifo.sv
// rtl/memory_sequencer_fifo.sv - DEPTH-entry command queue; full blocks push even on a same-cycle pop
module memory_sequencer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic [WIDTH-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_pop
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] FULL_COUNT = DEPTH[PTR_BITS:0];

    logic [WIDTH-1:0]    store [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS:0]   count;
    logic                push;
    logic                pop;

    assign in_tready  = (count != FULL_COUNT);
    assign out_tvalid = (count != '0);
    assign out_tdata  = store[rd_ptr];
    assign push       = in_tvalid && in_tready;
    assign pop        = out_pop && out_tvalid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push) store[wr_ptr] <= in_tdata;
    end

endmodule

// File: rtl/memory_sequencer.sv
// rtl/memory_sequencer.sv - queued command issue to an array memory; MEMORY_SEQUENCER_STATS_EN adds issue/drop counters
module memory_sequencer
    import memory_pkg::*;
#(
    parameter int ARRAY_BITS = 16,
    parameter int INDEX_BITS = 3,
    parameter int DATA_BITS  = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [7:0]            req_action,
    input  logic [ARRAY_BITS-1:0] req_array,
    input  logic [INDEX_BITS-1:0] req_index,
    input  logic [DATA_BITS-1:0]  req_in,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_BITS-1:0]  rsp_data,
    output logic [7:0]            mem_action,
    output logic [ARRAY_BITS-1:0] mem_array,
    output logic [INDEX_BITS-1:0] mem_index,
    output logic [DATA_BITS-1:0]  mem_in,
    input  logic [DATA_BITS-1:0]  mem_out
`ifdef MEMORY_SEQUENCER_STATS_EN
    ,
    output logic [15:0]           stat_issued,
    output logic [15:0]           stat_dropped
`endif
);

    localparam int CMD_BITS = 8 + ARRAY_BITS + INDEX_BITS + DATA_BITS;

    seq_state_t            state;
    logic                  cur_resp;
    logic [CMD_BITS-1:0]   req_cmd;
    logic [CMD_BITS-1:0]   head_cmd;
    logic [CMD_BITS-1:0]   next_cmd;
    logic                  head_valid;
    logic                  push_fire;
    logic                  go_issue;
    logic                  start_issue;
    logic [7:0]            next_action;
    logic [ARRAY_BITS-1:0] next_array;
    logic [INDEX_BITS-1:0] next_index;
    logic [DATA_BITS-1:0]  next_in;

    assign req_cmd = {req_action, req_array, req_index, req_in};

    memory_sequencer_fifo #(
        .WIDTH (CMD_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_tdata   (req_cmd),
        .in_tvalid  (req_valid),
        .in_tready  (req_ready),
        .out_tdata  (head_cmd),
        .out_tvalid (head_valid),
        .out_pop    (state == ST_ISSUE)
    );

    // An empty queue accepting a command this edge forwards it straight into ISSUE;
    // the entry itself is still queued and popped at the end of ISSUE.
    assign push_fire = req_valid && req_ready;
    assign go_issue  = head_valid || push_fire;
    assign next_cmd  = head_valid ? head_cmd : req_cmd;
    assign {next_action, next_array, next_index, next_in} = next_cmd;

    // Leaving WAIT/RESP passes through IDLE in zero cycles when work is pending.
    assign start_issue = go_issue &&
                         ((state == ST_IDLE) ||
                          (state == ST_WAIT && !cur_resp) ||
                          (state == ST_RESP && rsp_ready));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cur_resp   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            mem_action <= '0;
            mem_array  <= '0;
            mem_index  <= '0;
            mem_in     <= '0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_IDLE;
                ST_ISSUE: begin
                    mem_action <= '0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cur_resp) begin
                        rsp_data  <= mem_out;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (start_issue) begin
                state      <= ST_ISSUE;
                cur_resp   <= has_response(next_action);
                mem_action <= is_legal(next_action) ? next_action : 8'd0;
                mem_array  <= next_array;
                mem_index  <= next_index;
                mem_in     <= next_in;
            end
        end
    end

`ifdef MEMORY_SEQUENCER_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_issued  <= '0;
            stat_dropped <= '0;
        end else if (start_issue) begin
            if (is_legal(next_action)) begin
                if (stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
            end else begin
                if (stat_dropped != 16'hFFFF) stat_dropped <= stat_dropped + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_sequencer.sv
// tb/tb_memory_sequencer.sv - scoreboard bench for memory_sequencer with a behavioural array memory
module tb_memory_sequencer;

    localparam int ARRAY_BITS = 16;
    localparam int INDEX_BITS = 3;
    localparam int DATA_BITS  = 16;
    localparam int DEPTH      = 4;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b1;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [7:0]            req_action = '0;
    logic [ARRAY_BITS-1:0] req_array = '0;
    logic [INDEX_BITS-1:0] req_index = '0;
    logic [DATA_BITS-1:0]  req_in = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [DATA_BITS-1:0]  rsp_data;
    logic [7:0]            mem_action;
    logic [ARRAY_BITS-1:0] mem_array;
    logic [INDEX_BITS-1:0] mem_index;
    logic [DATA_BITS-1:0]  mem_in;
    logic [DATA_BITS-1:0]  mem_out = '0;
`ifdef MEMORY_SEQUENCER_STATS_EN
    logic [15:0]           stat_issued;
    logic [15:0]           stat_dropped;
`endif

    memory_sequencer #(
        .ARRAY_BITS (ARRAY_BITS),
        .INDEX_BITS (INDEX_BITS),
        .DATA_BITS  (DATA_BITS),
        .DEPTH      (DEPTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_action (req_action),
        .req_array  (req_array),
        .req_index  (req_index),
        .req_in     (req_in),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .mem_action (mem_action),
        .mem_array  (mem_array),
        .mem_index  (mem_index),
        .mem_in     (mem_in),
        .mem_out    (mem_out)
`ifdef MEMORY_SEQUENCER_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_dropped (stat_dropped)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  act;
        logic [15:0] arr;
        logic [2:0]  idx;
        logic [15:0] din;
    } issue_t;

    issue_t      exp_issue[$];
    logic [15:0] exp_rsp[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          issues_seen = 0;
    int          last_issue_cyc = -1;
    int          last_gap = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Behavioural array memory: 8 arrays x 8 entries, result one cycle after the issuing edge.
    logic [15:0] mdata [8][8];
    logic [15:0] msize [8];
    int          ma, mi, cnt;

    initial begin
        for (int a = 0; a < 8; a++) begin
            msize[a] = '0;
            for (int i = 0; i < 8; i++) mdata[a][i] = '0;
        end
    end

    always @(posedge clock) begin
        if (mem_action != 8'd0) begin
            ma = int'(mem_array[2:0]);
            mi = int'(mem_index);
            case (mem_action)
                8'd1: begin msize[ma] = '0; mem_out <= '0; end
                8'd2: begin
                    mdata[ma][mi] = mem_in;
                    if (int'(msize[ma]) < mi + 1) msize[ma] = 16'(mi + 1);
                    mem_out <= mem_in;
                end
                8'd3: mem_out <= mdata[ma][mi];
                8'd4: mem_out <= msize[ma];
                8'd5: mdata[ma][mi] = mdata[ma][mi] + 16'd1;
                8'd8, 8'd9: begin
                    cnt = 0;
                    for (int i = 0; i < 8; i++) begin
                        if (i < int'(msize[ma])) begin
                            if (mem_action == 8'd8 && mdata[ma][i] < mem_in) cnt++;
                            if (mem_action == 8'd9 && mdata[ma][i] > mem_in) cnt++;
                        end
                    end
                    mem_out <= 16'(cnt);
                end
                default: ;
            endcase
        end
    end

    logic [7:0] prev_action = '0;
    issue_t     got_e;

    always @(negedge clock) begin
        if (mem_action != 8'd0) begin
            check("mem_action_single_cycle", 32'(prev_action), 0);
            check("mem_action_legal", 32'(mem_action <= 8'd17), 1);
            if (exp_issue.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got action %0d expected none", mem_action);
            end else begin
                got_e = exp_issue.pop_front();
                check("issue_action", 32'(mem_action), 32'(got_e.act));
                check("issue_array", 32'(mem_array), 32'(got_e.arr));
                check("issue_index", 32'(mem_index), 32'(got_e.idx));
                check("issue_in", 32'(mem_in), 32'(got_e.din));
            end
            issues_seen++;
            if (last_issue_cyc >= 0) last_gap = cyc - last_issue_cyc;
            last_issue_cyc = cyc;
        end
        prev_action = mem_action;
    end

    logic        held = 1'b0;
    logic [15:0] held_data = '0;

    always @(negedge clock) begin
        if (rsp_valid && rsp_ready) begin
            if (held) check("rsp_stable_at_accept", 32'(rsp_data), 32'(held_data));
            if (exp_rsp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got %0h expected none", rsp_data);
            end else begin
                check("rsp_data", 32'(rsp_data), 32'(exp_rsp.pop_front()));
            end
            held = 1'b0;
        end else if (rsp_valid) begin
            if (held) check("rsp_hold", 32'(rsp_data), 32'(held_data));
            held      = 1'b1;
            held_data = rsp_data;
        end else begin
            if (held) begin
                checks++;
                errors++;
                $display("FAIL rsp_dropped: got rsp_valid 0 expected 1 until accepted");
            end
            held = 1'b0;
        end
    end

    task automatic send(input logic [7:0] a, input logic [15:0] arr, input logic [2:0] idx,
                        input logic [15:0] din, input logic resp, input logic [15:0] exp_data);
        int     guard = 0;
        issue_t e;
        @(negedge clock);
        req_action = a;
        req_array  = arr;
        req_index  = idx;
        req_in     = din;
        req_valid  = 1'b1;
        while (!req_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got req_ready 0 expected 1 for action %0d", a);
            req_valid = 1'b0;
            return;
        end
        if (a >= 8'd1 && a <= 8'd17) begin
            e.act = a; e.arr = arr; e.idx = idx; e.din = din;
            exp_issue.push_back(e);
        end
        if (resp) exp_rsp.push_back(exp_data);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_rsp.size() != 0 || exp_issue.size() != 0) && guard < 300) begin
            @(posedge clock);
            guard++;
        end
        checks++;
        if (guard >= 300) begin
            errors++;
            $display("FAIL drain_timeout: got %0d rsp and %0d issue pending expected 0",
                     exp_rsp.size(), exp_issue.size());
        end
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic latency_write(input string tag, input logic [15:0] din);
        send(8'd2, 16'd1, 3'd2, din, 1'b1, din);
        check({tag, "_action_e0"}, 32'(mem_action), 2);
        @(posedge clock); #1;
        check({tag, "_action_e1"}, 32'(mem_action), 0);
        check({tag, "_rsp_e1"}, 32'(rsp_valid), 0);
        @(posedge clock); #1;
        check({tag, "_rsp_e2"}, 32'(rsp_valid), 1);
        check({tag, "_data_e2"}, 32'(rsp_data), 32'(din));
        drain();
    endtask

    int issued_before;
`ifdef MEMORY_SEQUENCER_STATS_EN
    logic [15:0] st_i0, st_d0;
`endif

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_data", 32'(rsp_data), 0);
        check("reset_mem_action", 32'(mem_action), 0);
        check("reset_mem_array", 32'(mem_array), 0);
        check("reset_mem_index", 32'(mem_index), 0);
        check("reset_mem_in", 32'(mem_in), 0);
        check("reset_req_ready", 32'(req_ready), 1);
`ifdef MEMORY_SEQUENCER_STATS_EN
        check("reset_stat_issued", 32'(stat_issued), 0);
        check("reset_stat_dropped", 32'(stat_dropped), 0);
`endif
        reset_n = 1'b1;

        latency_write("t1", 16'h00AB);

        send(8'd2, 16'd2, 3'd0, 16'd5, 1'b1, 16'd5);
        send(8'd2, 16'd2, 3'd1, 16'd3, 1'b1, 16'd3);
        send(8'd2, 16'd2, 3'd2, 16'd9, 1'b1, 16'd9);
        send(8'd8, 16'd2, 3'd0, 16'd5, 1'b1, 16'd1);
        send(8'd9, 16'd2, 3'd0, 16'd5, 1'b1, 16'd1);
        send(8'd4, 16'd2, 3'd0, 16'd0, 1'b1, 16'd3);
        drain();
        check("t2_responding_gap", 32'(last_gap), 3);

        rsp_ready = 1'b0;
        send(8'd3, 16'd2, 3'd0, 16'd0, 1'b1, 16'd5);
        send(8'd3, 16'd2, 3'd1, 16'd0, 1'b1, 16'd3);
        send(8'd3, 16'd2, 3'd2, 16'd0, 1'b1, 16'd9);
        send(8'd3, 16'd2, 3'd0, 16'd0, 1'b1, 16'd5);
        send(8'd3, 16'd2, 3'd1, 16'd0, 1'b1, 16'd3);
        repeat (3) @(posedge clock);
        #1;
        check("t3_full_req_ready", 32'(req_ready), 0);
        check("t3_held_valid", 32'(rsp_valid), 1);
        check("t3_held_data", 32'(rsp_data), 5);
        rsp_ready = 1'b1;
        drain();

        issued_before = issues_seen;
`ifdef MEMORY_SEQUENCER_STATS_EN
        st_i0 = stat_issued;
        st_d0 = stat_dropped;
`endif
        send(8'd0,  16'd2, 3'd0, 16'd0, 1'b0, 16'd0);
        send(8'd20, 16'd2, 3'd0, 16'd0, 1'b0, 16'd0);
        send(8'd5,  16'd2, 3'd0, 16'd0, 1'b0, 16'd0);
        drain();
        check("t4_issues_seen", 32'(issues_seen - issued_before), 1);
`ifdef MEMORY_SEQUENCER_STATS_EN
        check("t4_stat_dropped", 32'(stat_dropped - st_d0), 2);
        check("t4_stat_issued", 32'(stat_issued - st_i0), 1);
`endif

        send(8'd12, 16'd1, 3'd0, 16'd0, 1'b0, 16'd0);
        send(8'd13, 16'd3, 3'd1, 16'd2, 1'b0, 16'd0);
        drain();
        check("t5_silent_gap", 32'(last_gap), 2);

        send(8'd3, 16'd1, 3'd2, 16'd0, 1'b0, 16'd0);
        @(posedge clock); #1;
        check("t6_wait_no_rsp", 32'(rsp_valid), 0);
        reset_n = 1'b0;
        #1;
        check("t6_reset_rsp_valid", 32'(rsp_valid), 0);
        check("t6_reset_req_ready", 32'(req_ready), 1);
        check("t6_reset_mem_array", 32'(mem_array), 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("t6_after_rsp_valid", 32'(rsp_valid), 0);
        check("t6_after_mem_action", 32'(mem_action), 0);
        latency_write("t6", 16'h00CD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/memory_sequencer.md
MEMORY_SEQUENCER -- requirements
Module: memory_sequencer

Interface
REQ-001 Parameter ARRAY_BITS, default 16: width of the array-number field.
REQ-002 Parameter INDEX_BITS, default 3: width of the index field.
REQ-003 Parameter DATA_BITS, default 16: width of the data fields.
REQ-004 Parameter DEPTH, default 4, power of two >= 2: number of command queue entries.
REQ-005 Port clock, input, 1: single clock; all state updates on posedge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port req_valid / req_ready, input / output, 1 each: command handshake; a command transfers on a posedge with both high.
REQ-008 Port req_action, input, 8: memory action code, 1..17.
REQ-009 Ports req_array (ARRAY_BITS), req_index (INDEX_BITS), req_in (DATA_BITS), inputs: command operands.
REQ-010 Port rsp_valid / rsp_ready, output / input, 1 each: response handshake.
REQ-011 Port rsp_data, output, DATA_BITS: captured memory result.
REQ-012 Ports mem_action (8), mem_array, mem_index, mem_in, outputs: drive the downstream array memory.
REQ-013 Port mem_out, input, DATA_BITS: memory result, valid the cycle after the issuing edge.

Function
REQ-014 Queue: DEPTH-entry FIFO of {action, array, index, in}.
- req_ready = !full, derived from registered occupancy only.
- When full, no push occurs even if a pop happens in the same cycle.
REQ-015 Issue FSM states and transitions:
- IDLE -> ISSUE when the queue is non-empty.
- ISSUE -> WAIT unconditionally.
- WAIT -> RESP if the action is a responding action, otherwise -> IDLE.
- RESP -> IDLE on rsp_ready.
REQ-016 ISSUE (exactly one cycle): mem_* are driven from the queue head and the head is popped. mem_action = 0 in every other state; mem_array/index/in hold their last values.
REQ-017 Illegal action (0 or >17): popped in ISSUE with mem_action held 0; no response.
REQ-018 Responding actions: Write(2), Read(3), Size(4), Index(7), Less(8), Greater(9), Pop(15). All other legal actions retire silently.
REQ-019 WAIT, responding action: rsp_data <= mem_out and rsp_valid <= 1 at the end of WAIT. rsp_data is registered and holds until the next capture.
REQ-020 rsp_valid stays high with rsp_data stable until rsp_ready; it drops on the accepting edge.
REQ-021 Latency, empty queue, rsp_ready held high: command accepted at edge E0 -> mem_action nonzero in cycle E0..E1 -> rsp_valid high from E2.
REQ-022 Throughput: one silent command per 2 cycles; one responding command per 3 cycles.
REQ-023 No queue reordering; Long1 (12) and Long2 (13) are issued in order with no interleaving reinterpretation.
REQ-024 Pop (15) on an empty array returns whatever mem_out holds; no special handling.

Reset
REQ-025 reset_n low asynchronously sets: queue empty, state IDLE, rsp_valid 0, rsp_data 0, mem_action/mem_array/mem_index/mem_in 0.
REQ-026 Reset mid-operation discards all queued and in-flight commands and any pending response; a memory action already clocked is not undone.

Configuration
REQ-027 Macro MEMORY_SEQUENCER_STATS_EN defined adds outputs stat_issued (16) and stat_dropped (16).
- stat_issued increments per legal action issued; stat_dropped increments per illegal action.
- Both saturate at 16'hFFFF and reset to 0.
REQ-028 Macro undefined: the stat ports and counters do not exist; all other behaviour is identical.

Structure
REQ-029 Package memory_pkg holds the action code constants ACT_RESET..ACT_RESIZE (1..17), the has_response(action) function, and the FSM state enum.
REQ-030 Sub-module memory_sequencer_fifo, parameterised by width and DEPTH, implements the queue.

Verification
REQ-031 Reset, then Write(array 1, index 2, in 0x00AB) -> mem_action=2 for exactly one cycle; rsp_valid at E2 with rsp_data=0x00AB.
REQ-032 Write 5, 3, 9 to array 2 indices 0..2, then Less(in 5) -> rsp_data=1; Greater(in 5) -> rsp_data=1; Size -> rsp_data=3.
REQ-033 With rsp_ready held low, push 5 Read commands (DEPTH=4) -> first response held stable; req_ready low once the queue fills; no loss after release.
REQ-034 Push action 0, then 20, then Inc(5) -> no response; mem_action never 0 or 20; with STATS_EN: stat_dropped=2, stat_issued=1.
REQ-035 Assert reset_n low during WAIT of a Read -> rsp_valid stays 0; queue empty; next command behaves per REQ-021.
REQ-036 Long1(array 1, index 0), then Long2(array 3, index 1, in 2) -> issued in order on consecutive ISSUE states; no responses.
